// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit.
// The multiplier uses shift-add and the divider uses restoring division, one
// step per cycle on operand magnitudes. The result sign is fixed up
// combinationally from the stored magnitudes while the result is presented.
module mul_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] in_1,
  input  logic [XLEN-1:0] in_2,
  input  logic [4:0]      rd_tag,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_tag,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned PW    = 2 * XLEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [4:0]        r_out_tag;
  logic [2:0]        r_op;
  // r_hi: MUL accumulator / DIV partial remainder
  // r_lo: MUL multiplier (product low half) / DIV dividend becoming quotient
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic              r_sign_1;
  logic              r_sign_2;

  logic              w_signed_1;
  logic              w_signed_2;
  logic              w_neg_1;
  logic              w_neg_2;
  logic [XLEN-1:0]   w_mag_1;
  logic [XLEN-1:0]   w_mag_2;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_last;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_shift;
  logic              w_div_ge;
  logic [PW-1:0]     w_prod;
  logic [PW-1:0]     w_prod_fix;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_res;

  // Operand signedness by op: MULHSU treats only rs1 as signed
  assign w_signed_1 = funct3[2] ? ~funct3[0] : (funct3 != 3'b011);
  assign w_signed_2 = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign w_neg_1    = w_signed_1 & in_1[XLEN-1];
  assign w_neg_2    = w_signed_2 & in_2[XLEN-1];
  assign w_mag_1    = w_neg_1 ? (~in_1 + XLEN'(1)) : in_1;
  assign w_mag_2    = w_neg_2 ? (~in_2 + XLEN'(1)) : in_2;

  // Special division cases resolved at accept without iterating
  assign w_div_zero = (in_2 == '0);
  assign w_div_ovf  = funct3[2] & ~funct3[0]
                    & (in_1 == {1'b1, {(XLEN-1){1'b0}}})
                    & (&in_2);

  assign w_last = (r_cnt == CNT_W'(XLEN - 1));

  // One shift-add step: conditionally add multiplicand, then shift right
  assign w_mul_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};

  // One restoring step: shift next dividend bit into remainder, trial subtract
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});

  // Sign correction of the stored magnitudes
  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = (r_sign_1 ^ r_sign_2) ? (~w_prod + PW'(1)) : w_prod;
  assign w_quo      = (r_sign_1 ^ r_sign_2) ? (~r_lo + XLEN'(1)) : r_lo;
  assign w_rem      = r_sign_1 ? (~r_hi + XLEN'(1)) : r_hi;

  // Select the architectural result for the captured op
  always_comb begin
    w_res = '0;
    case (r_op)
      3'b000:                 w_res = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_res = w_prod_fix[PW-1:XLEN];
      3'b100, 3'b101:         w_res = w_quo;
      default:                w_res = w_rem;
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_tag   = r_out_tag;
  assign result    = r_out_valid ? w_res : '0;

  // Control FSM and iterative datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      r_op        <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_sign_1    <= 1'b0;
      r_sign_2    <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op       <= funct3;
            r_out_tag  <= rd_tag;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_b        <= w_mag_2;
            if (!funct3[2]) begin
              r_state  <= S_MUL;
              r_hi     <= '0;
              r_lo     <= w_mag_1;
              r_sign_1 <= w_neg_1;
              r_sign_2 <= w_neg_2;
            end else if (w_div_zero) begin
              // quotient all ones, remainder is the raw dividend
              r_state  <= S_DONE;
              r_hi     <= in_1;
              r_lo     <= '1;
              r_sign_1 <= 1'b0;
              r_sign_2 <= 1'b0;
            end else if (w_div_ovf) begin
              // most-negative / -1: quotient wraps, remainder zero
              r_state  <= S_DONE;
              r_hi     <= '0;
              r_lo     <= {1'b1, {(XLEN-1){1'b0}}};
              r_sign_1 <= 1'b0;
              r_sign_2 <= 1'b0;
            end else begin
              r_state  <= S_DIV;
              r_hi     <= '0;
              r_lo     <= w_mag_1;
              r_sign_1 <= w_neg_1;
              r_sign_2 <= w_neg_2;
            end
          end
        end
        S_MUL: begin
          r_hi  <= w_mul_sum[XLEN:1];
          r_lo  <= {w_mul_sum[0], r_lo[XLEN-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DIV: begin
          r_hi  <= w_div_ge ? XLEN'(w_div_shift - {1'b0, r_b})
                            : w_div_shift[XLEN-1:0];
          r_lo  <= {r_lo[XLEN-2:0], w_div_ge};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // out_valid rises one edge after entering DONE, held until taken
          if (r_out_valid) begin
            if (out_ready) begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
            end
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with a result scoreboard.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] in_1;
  logic [31:0] in_2;
  logic [4:0]  rd_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_tag;
  logic [31:0] result;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic [4:0] next_tag = 5'd1;

  mul_div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .in_1      (in_1),
    .in_2      (in_2),
    .rd_tag    (rd_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Issue one op (called just after a negedge), then wait, check and consume it
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int hold);
    exp_t e;
    int   edges;
    logic ir_ok;
    logic [4:0] tg;
    tg = next_tag;
    next_tag = next_tag + 5'd1;
    in_valid = 1'b1;
    funct3   = f3;
    in_1     = a;
    in_2     = b;
    rd_tag   = tg;
    check({name, "_rdy"}, 64'(in_ready), 64'd1);
    sb.push_back('{tag: tg, res: exp});
    @(posedge clk); #1;
    in_valid = 1'b0;
    funct3   = 3'($urandom);
    in_1     = $urandom;
    in_2     = $urandom;
    rd_tag   = 5'($urandom);
    edges = 0;
    ir_ok = 1'b1;
    while (out_valid !== 1'b1 && edges < 200) begin
      if (in_ready !== 1'b0) ir_ok = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    if (in_ready !== 1'b0) ir_ok = 1'b0;
    check({name, "_lat"}, 64'(edges), 64'(lat));
    check({name, "_busy"}, 64'(ir_ok), 64'd1);
    if (sb.size() == 0) begin
      check({name, "_sb"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({name, "_res"}, 64'(result), 64'(e.res));
      check({name, "_tag"}, 64'(out_tag), 64'(e.tag));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({name, "_hold"}, 64'({out_valid, in_ready, out_tag, result}),
              64'({1'b1, 1'b0, e.tag, e.res}));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_ret"}, 64'({out_valid, in_ready}), 64'(2'b01));
    @(negedge clk);
  endtask

  initial begin
    logic        ov_seen;
    logic [31:0] ra;
    logic [31:0] rb;
    reset     = 1'b1;
    in_valid  = 1'b0;
    funct3    = 3'd0;
    in_1      = '0;
    in_2      = '0;
    rd_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_state", 64'({in_ready, out_valid, out_tag, result}), 64'({1'b1, 1'b0, 5'd0, 32'd0}));

    run_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    run_op("mulh",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 0);
    run_op("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
    run_op("div_-7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0);
    run_op("rem_-7/2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0);
    run_op("divu",     3'b101, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op("remu",     3'b111, 32'd100, 32'd7, 32'd2, 33, 0);
    run_op("div_z",    3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
    run_op("rem_z",    3'b110, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0);
    run_op("hold",     3'b101, 32'd1000, 32'd10, 32'd100, 33, 5);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom | 32'd1;
      run_op("rnd_mul",  3'b000, ra, rb, ra * rb, 33, 0);
      run_op("rnd_divu", 3'b101, ra, rb, ra / rb, 33, 0);
      run_op("rnd_remu", 3'b111, ra, rb, ra % rb, 33, 0);
    end

    // Flush after 10 DIV steps, with a competing request on the same edge
    in_valid = 1'b1;
    funct3   = 3'b100;
    in_1     = 32'd12345;
    in_2     = 32'd67;
    rd_tag   = 5'd30;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_idle", 64'({in_ready, out_valid}), 64'(2'b10));
    ov_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) ov_seen = 1'b1;
    end
    check("flush_noval", 64'(ov_seen), 64'd0);
    @(negedge clk);

    // Reset after 20 MUL steps, with flush and a request also asserted
    in_valid = 1'b1;
    funct3   = 3'b000;
    in_1     = 32'd99;
    in_2     = 32'd77;
    rd_tag   = 5'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset    = 1'b1;
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("rst_idle", 64'({in_ready, out_valid, out_tag, result}), 64'({1'b1, 1'b0, 5'd0, 32'd0}));
    ov_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) ov_seen = 1'b1;
    end
    check("rst_noval", 64'(ov_seen), 64'd0);
    @(negedge clk);

    run_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 33, 0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
